// File: rtl/iterative_subtractor_pkg.sv
// Shared definitions for the block-serial subtractor: FSM states and block-count helper.
// Pure declarations; no logic or latency of its own.
package iterative_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int n, input int x);
        return (n + x - 1) / x;
    endfunction

endpackage

// File: rtl/iterative_subtractor_rca.sv
// Purpose: W-bit ripple-carry adder with carry taps around bit TAP (for overflow/borrow flags).
// Latency: combinational. Backpressure: none, pure function of inputs.
module iterative_subtractor_rca #(
    parameter int W   = 4,
    parameter int TAP = W - 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         tap_cin,
    output logic         tap_cout
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[W];
    assign tap_cin  = c[TAP];
    assign tap_cout = c[TAP + 1];

endmodule

// File: rtl/iterative_subtractor.sv
// Purpose: D = A - B - Bin, one X-bit block per clock (LSB first) through a single X-bit adder.
// Latency: start accepted -> done after NUM_BLOCKS+1 cycles. Backpressure: start ignored while busy.
module iterative_subtractor
    import iterative_subtractor_pkg::*;
#(
    parameter int N = 16,
    parameter int X = 4
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         V,
    output logic         Z
);

    localparam int NUM_BLOCKS = ceil_div(N, X);
    localparam int PW         = NUM_BLOCKS * X;
    localparam int IDXW       = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int TAP        = (N - 1) % X;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BLOCKS - 1);

    state_t          state;
    logic [PW-1:0]   a_q;
    logic [PW-1:0]   nb_q;
    logic [PW-1:0]   d_q;
    logic [PW-1:0]   d_next;
    logic            carry_q;
    logic [IDXW-1:0] idx;
    logic [N-1:0]    b_inv;
    logic [X-1:0]    blk_a;
    logic [X-1:0]    blk_b;
    logic [X-1:0]    blk_sum;
    logic            blk_cout;
    logic            tap_cin;
    logic            tap_cout;

    assign b_inv = ~B;
    assign blk_a = a_q[int'(idx) * X +: X];
    assign blk_b = nb_q[int'(idx) * X +: X];

    iterative_subtractor_rca #(
        .W   (X),
        .TAP (TAP)
    ) u_rca (
        .a        (blk_a),
        .b        (blk_b),
        .cin      (carry_q),
        .sum      (blk_sum),
        .cout     (blk_cout),
        .tap_cin  (tap_cin),
        .tap_cout (tap_cout)
    );

    // Final-cycle view of D so Z sees the block being written this cycle.
    always_comb begin
        d_next = d_q;
        d_next[int'(idx) * X +: X] = blk_sum;
    end

    assign D = d_q[N-1:0];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            d_q     <= '0;
            Bout    <= 1'b0;
            V       <= 1'b0;
            Z       <= 1'b0;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            nb_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Padding bits stay zero so they never feed the flags.
                        a_q     <= PW'(A);
                        nb_q    <= PW'(b_inv);
                        carry_q <= ~Bin;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    d_q     <= d_next;
                    carry_q <= blk_cout;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        Bout  <= ~tap_cout;
                        V     <= tap_cin ^ tap_cout;
                        Z     <= (d_next[N-1:0] == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_subtractor.sv
// Bench for iterative_subtractor: N=16/X=4 instance checked every cycle against a
// transaction-level model, plus an N=10/X=4 instance for the partial-last-block case.
module tb_iterative_subtractor;

    typedef struct packed {
        logic [15:0] d;
        logic        bout;
        logic        v;
        logic        z;
    } res_t;

    localparam int NB0 = 4;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic        reset0 = 1'b1, start0 = 1'b0, Bin0 = 1'b0;
    logic [15:0] A0 = '0, B0 = '0;
    logic        busy0, done0, Bout0, V0, Z0;
    logic [15:0] D0;

    logic        reset1 = 1'b1, start1 = 1'b0, Bin1 = 1'b0;
    logic [9:0]  A1 = '0, B1 = '0;
    logic        busy1, done1, Bout1, V1, Z1;
    logic [9:0]  D1;

    int checks = 0;
    int errors = 0;

    iterative_subtractor #(.N(16), .X(4)) dut0 (
        .CLOCK_50 (CLOCK_50), .reset (reset0), .start (start0),
        .A (A0), .B (B0), .Bin (Bin0),
        .busy (busy0), .done (done0), .D (D0), .Bout (Bout0), .V (V0), .Z (Z0)
    );

    iterative_subtractor #(.N(10), .X(4)) dut1 (
        .CLOCK_50 (CLOCK_50), .reset (reset1), .start (start1),
        .A (A1), .B (B1), .Bin (Bin1),
        .busy (busy1), .done (done1), .D (D1), .Bout (Bout1), .V (V1), .Z (Z1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic on n-bit operands: unsigned borrow and signed range overflow.
    function automatic res_t ref_sub(input int n, input logic [15:0] a, input logic [15:0] b,
                                     input logic bin);
        res_t   r;
        longint mask, half, ua, ub, diff, sa, sb, sd;
        mask = (longint'(1) << n) - 1;
        half = longint'(1) << (n - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        diff = ua - ub - longint'(bin);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        sd   = sa - sb - longint'(bin);
        r.d    = 16'(diff & mask);
        r.bout = (diff < 0);
        r.v    = (sd < -half) || (sd >= half);
        r.z    = ((diff & mask) == 0);
        return r;
    endfunction

    // Transaction model for dut0: counts remaining run cycles, publishes result at done.
    int   m_left  = 0;
    logic m_done  = 1'b0;
    logic m_valid = 1'b0;
    logic m_init  = 1'b0;
    res_t m_res   = '0;
    res_t m_pend  = '0;

    always @(posedge CLOCK_50) begin
        if (reset0) begin
            m_left  = 0;
            m_done  = 1'b0;
            m_valid = 1'b1;
            m_res   = '0;
            m_init  = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done  = 1'b1;
                    m_res   = m_pend;
                    m_valid = 1'b1;
                end
            end else if (start0) begin
                m_pend  = ref_sub(16, A0, B0, Bin0);
                m_left  = NB0;
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (m_init) begin
            check("busy", 32'(busy0), 32'(m_left > 0));
            check("done", 32'(done0), 32'(m_done));
            if (m_valid) begin
                check("D",    32'(D0),    32'(m_res.d));
                check("Bout", 32'(Bout0), 32'(m_res.bout));
                check("V",    32'(V0),    32'(m_res.v));
                check("Z",    32'(Z0),    32'(m_res.z));
            end
        end
    end

    // Starts one op on the chosen instance and returns cycles from start to done and busy count.
    task automatic run_op(input int which, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, output int lat, output int bcnt);
        @(negedge CLOCK_50);
        if (which == 0) begin A0 = a; B0 = b; Bin0 = bin; start0 = 1'b1; end
        else begin A1 = a[9:0]; B1 = b[9:0]; Bin1 = bin; start1 = 1'b1; end
        @(negedge CLOCK_50);
        start0 = 1'b0;
        start1 = 1'b0;
        lat  = 1;
        bcnt = (which == 0) ? int'(busy0) : int'(busy1);
        while (!((which == 0) ? done0 : done1) && lat < 40) begin
            @(negedge CLOCK_50);
            lat++;
            bcnt += (which == 0) ? int'(busy0) : int'(busy1);
        end
        if (!((which == 0) ? done0 : done1)) check("done_timeout", 0, 1);
    endtask

    task automatic wait_done0(inout int lat);
        while (!done0 && lat < 40) begin
            @(negedge CLOCK_50);
            lat++;
        end
        if (!done0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int   lat, bcnt;
        logic seen;
        res_t r;

        repeat (2) @(negedge CLOCK_50);
        check("rst_busy0", 32'(busy0), 0);
        check("rst_done0", 32'(done0), 0);
        check("rst_D0",    32'(D0),    0);
        check("rst_flags0", {29'd0, Bout0, V0, Z0}, 0);
        check("rst_busy1", 32'(busy1), 0);
        check("rst_D1",    32'(D1),    0);
        reset0 = 1'b0;
        reset1 = 1'b0;

        run_op(0, 16'h1234, 16'h0234, 1'b0, lat, bcnt);
        check("lat_basic",  lat, 5);
        check("busy_cycles", bcnt, 4);
        check("D_basic",    32'(D0), 32'h1000);
        check("flags_basic", {29'd0, Bout0, V0, Z0}, 0);

        run_op(0, 16'h0000, 16'h0001, 1'b0, lat, bcnt);
        check("D_wrap",    32'(D0),   32'hFFFF);
        check("Bout_wrap", 32'(Bout0), 1);
        check("V_wrap",    32'(V0),    0);
        run_op(0, 16'h8000, 16'h0001, 1'b0, lat, bcnt);
        check("D_ovf",    32'(D0),    32'h7FFF);
        check("V_ovf",    32'(V0),    1);
        check("Bout_ovf", 32'(Bout0), 0);

        // Result of 5-3-1, then start held in the DONE cycle for A==B.
        run_op(0, 16'h0005, 16'h0003, 1'b1, lat, bcnt);
        check("D_bin",    32'(D0),    32'h0001);
        check("Bout_bin", 32'(Bout0), 0);
        A0 = 16'hABCD; B0 = 16'hABCD; Bin0 = 1'b0; start0 = 1'b1;
        @(negedge CLOCK_50);
        start0 = 1'b0;
        lat = 6;
        wait_done0(lat);
        check("lat_b2b", lat, 10);
        check("D_zero",  32'(D0), 0);
        check("Z_zero",  32'(Z0), 1);

        // Spurious start in cycle 2 with other operands.
        @(negedge CLOCK_50);
        A0 = 16'h1234; B0 = 16'h0234; Bin0 = 1'b0; start0 = 1'b1;
        @(negedge CLOCK_50);
        start0 = 1'b0;
        @(negedge CLOCK_50);
        A0 = 16'hFFFF; B0 = 16'h0000; Bin0 = 1'b1; start0 = 1'b1;
        @(negedge CLOCK_50);
        start0 = 1'b0;
        lat = 3;
        wait_done0(lat);
        check("lat_ignore", lat, 5);
        check("D_ignore",   32'(D0), 32'h1000);

        // Reset in cycle 3 aborts the run.
        @(negedge CLOCK_50);
        A0 = 16'h0000; B0 = 16'h0001; start0 = 1'b1;
        @(negedge CLOCK_50);
        start0 = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset0 = 1'b1;
        @(negedge CLOCK_50);
        check("abort_busy",  32'(busy0), 0);
        check("abort_D",     32'(D0),    0);
        check("abort_flags", {29'd0, Bout0, V0, Z0}, 0);
        reset0 = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge CLOCK_50);
            seen |= done0;
        end
        check("abort_no_done", 32'(seen), 0);
        run_op(0, 16'h4000, 16'h4001, 1'b0, lat, bcnt);
        check("D_after_abort", 32'(D0), 32'hFFFF);

        // N=10, X=4: partial last block.
        run_op(1, 16'h000, 16'h001, 1'b0, lat, bcnt);
        check("n10_lat",  lat, 4);
        check("n10_D",    32'(D1),    32'h3FF);
        check("n10_Bout", 32'(Bout1), 1);
        check("n10_V",    32'(V1),    0);
        run_op(1, 16'h200, 16'h001, 1'b0, lat, bcnt);
        check("n10_D_ovf", 32'(D1),    32'h1FF);
        check("n10_V_ovf", 32'(V1),    1);
        check("n10_Bout2", 32'(Bout1), 0);
        for (int i = 0; i < 25; i++) begin
            logic [15:0] ra, rb;
            logic        rbin;
            ra   = 16'($urandom_range(0, 1023));
            rb   = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom_range(0, 1023));
            rbin = 1'($urandom);
            r    = ref_sub(10, ra, rb, rbin);
            run_op(1, ra, rb, rbin, lat, bcnt);
            check("n10_rand_lat", lat, 4);
            check("n10_rand_res", {12'd0, D1, Bout1, V1, Z1}, {12'd0, r.d[9:0], r.bout, r.v, r.z});
        end

        // Free-running random stimulus on dut0; the per-cycle model checks everything.
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLOCK_50);
            reset0 = ($urandom_range(0, 199) == 0);
            start0 = ($urandom_range(0, 2) == 0);
            A0     = 16'($urandom);
            B0     = ($urandom_range(0, 7) == 0) ? A0 : 16'($urandom);
            Bin0   = 1'($urandom);
        end
        @(negedge CLOCK_50);
        reset0 = 1'b0;
        start0 = 1'b0;
        repeat (8) @(negedge CLOCK_50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
